// File: rtl/despachador_llamadas.sv
// Elevator call dispatcher: captures button presses, de-duplicates them, queues them in arrival order
// and issues one destination at a time to the car. Optional build macro: DESCARTE_PISO_ACTUAL_EN.
module despachador_llamadas #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [1:0]  PISO_INICIAL = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] botones,
  input  logic [1:0] piso,
  input  logic       ocupado,
  input  logic       puertas_abiertas,
  output logic [2:0] destino,
  output logic [3:0] pendientes,
  output logic [4:0] en_cola,
  output logic       llena
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {REPOSO, EMITIDO, EN_CURSO} estado_t;

  estado_t       estado, estado_sig;
  logic [3:0]    btn_prev, pend_q, por_encolar;
  logic [3:0]    flanco, nuevos, descarte, clr_mask, push_mask;
  logic [1:0]    push_code;
  logic          push, pop, completar, hallado, llena_int;
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [4:0]    cnt;
  logic [2:0]    destino_q;

  function automatic logic [PW-1:0] sig_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign llena_int = (cnt == 5'(DEPTH));

  always_comb begin
    flanco = botones & ~btn_prev;
`ifdef DESCARTE_PISO_ACTUAL_EN
    descarte = puertas_abiertas ? (4'b0001 << piso) : '0;
`else
    // doors only matter when the discard feature is built in
    descarte = {4{1'b0 & puertas_abiertas}};
`endif
    // in-flight floor stays pending, so its presses (including the completion cycle) fall out here
    nuevos = flanco & ~pend_q & ~descarte;

    push_code = '0;
    push_mask = '0;
    hallado   = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (por_encolar[i] && !hallado) begin
        push_code    = 2'(i);
        push_mask[i] = 1'b1;
        hallado      = 1'b1;
      end
    end
    push     = hallado && !llena_int;
    clr_mask = completar ? (4'b0001 << destino_q[1:0]) : '0;
  end

  always_comb begin
    estado_sig = estado;
    pop        = 1'b0;
    completar  = 1'b0;
    case (estado)
      REPOSO: begin
        if (cnt != '0 && !ocupado) begin
          pop        = 1'b1;
          estado_sig = EMITIDO;
        end
      end
      EMITIDO: begin
        if (ocupado) begin
          estado_sig = EN_CURSO;
        end else if (piso == destino_q[1:0]) begin
          completar  = 1'b1;
          estado_sig = REPOSO;
        end
      end
      EN_CURSO: begin
        if (!ocupado) begin
          completar  = 1'b1;
          estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= REPOSO;
    else     estado <= estado_sig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev    <= '0;
      pend_q      <= '0;
      por_encolar <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      destino_q   <= {1'b1, PISO_INICIAL};
    end else begin
      btn_prev    <= botones;
      pend_q      <= (pend_q & ~clr_mask) | nuevos;
      por_encolar <= (por_encolar & ~(push ? push_mask : 4'b0000)) | nuevos;
      if (push) wr_ptr <= sig_ptr(wr_ptr);
      if (pop) begin
        rd_ptr    <= sig_ptr(rd_ptr);
        destino_q <= {1'b0, mem[rd_ptr]};
      end else if (completar) begin
        destino_q[2] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_code;
  end

  assign destino    = destino_q;
  assign pendientes = pend_q;
  assign en_cola    = cnt;
  assign llena      = llena_int;

endmodule

// File: tb/tb_despachador_llamadas.sv
// Directed self-checking bench for despachador_llamadas (default DEPTH=4 and a DEPTH=2 instance).
module tb_despachador_llamadas;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] botones, botones2;
  logic [1:0] piso, piso2;
  logic       ocupado, ocupado2, puertas, puertas2;
  logic [2:0] destino, destino2;
  logic [3:0] pendientes, pendientes2;
  logic [4:0] en_cola, en_cola2;
  logic       llena, llena2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  despachador_llamadas dut (
    .clk(clk), .rst(rst), .botones(botones), .piso(piso), .ocupado(ocupado),
    .puertas_abiertas(puertas), .destino(destino), .pendientes(pendientes),
    .en_cola(en_cola), .llena(llena)
  );

  despachador_llamadas #(.DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .botones(botones2), .piso(piso2), .ocupado(ocupado2),
    .puertas_abiertas(puertas2), .destino(destino2), .pendientes(pendientes2),
    .en_cola(en_cola2), .llena(llena2)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    botones = '0; botones2 = '0; piso = 2'b11; piso2 = 2'b11;
    ocupado = 1'b0; ocupado2 = 1'b0; puertas = 1'b0; puertas2 = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (destino !== 3'b111) begin failures++; $display("FAIL reset_destino got=%b exp=111", destino); end
    checks++; if (pendientes !== 4'b0000) begin failures++; $display("FAIL reset_pend got=%b exp=0000", pendientes); end
    checks++; if (en_cola !== 5'd0 || llena !== 1'b0) begin failures++; $display("FAIL reset_cola got=%0d/%b exp=0/0", en_cola, llena); end
    // button held through reset release counts as a press
    rst = 1'b1; botones = 4'b0001; step();
    rst = 1'b0; step();
    checks++; if (pendientes !== 4'b0001) begin failures++; $display("FAIL held_press got=%b exp=0001", pendientes); end
  endtask

  task automatic test_single();
    apply_reset();
    botones = 4'b0001; step();
    botones = 4'b0000;
    checks++; if (pendientes !== 4'b0001 || destino !== 3'b111) begin failures++; $display("FAIL s1_pend got=%b/%b exp=0001/111", pendientes, destino); end
    step();
    checks++; if (en_cola !== 5'd1 || destino !== 3'b111) begin failures++; $display("FAIL s1_push got=%0d/%b exp=1/111", en_cola, destino); end
    step();
    checks++; if (destino !== 3'b000 || en_cola !== 5'd0) begin failures++; $display("FAIL s1_issue got=%b/%0d exp=000/0", destino, en_cola); end
    ocupado = 1'b1; step();
    ocupado = 1'b0; step();
    checks++; if (destino !== 3'b100 || pendientes !== 4'b0000) begin failures++; $display("FAIL s1_done got=%b/%b exp=100/0000", destino, pendientes); end
  endtask

  task automatic test_order();
    apply_reset();
    ocupado = 1'b1;
    botones = 4'b1010; step();
    botones = 4'b0000; step(); step();
    checks++; if (en_cola !== 5'd2 || destino !== 3'b111 || pendientes !== 4'b1010) begin failures++; $display("FAIL ord_q got=%0d/%b/%b exp=2/111/1010", en_cola, destino, pendientes); end
    ocupado = 1'b0; step();
    checks++; if (destino !== 3'b001 || en_cola !== 5'd1) begin failures++; $display("FAIL ord_first got=%b/%0d exp=001/1", destino, en_cola); end
    ocupado = 1'b1; step();
    ocupado = 1'b0; step();
    checks++; if (destino !== 3'b101 || pendientes !== 4'b1000) begin failures++; $display("FAIL ord_done1 got=%b/%b exp=101/1000", destino, pendientes); end
    step();
    checks++; if (destino !== 3'b011 || en_cola !== 5'd0) begin failures++; $display("FAIL ord_second got=%b/%0d exp=011/0", destino, en_cola); end
    step();
    checks++; if (destino !== 3'b111 || pendientes !== 4'b0000) begin failures++; $display("FAIL ord_done2 got=%b/%b exp=111/0000", destino, pendientes); end
  endtask

  task automatic test_dedup();
    apply_reset();
    ocupado = 1'b1;
    for (int i = 0; i < 3; i++) begin
      botones = 4'b0100; step();
      botones = 4'b0000; step();
    end
    checks++; if (en_cola !== 5'd1 || pendientes !== 4'b0100) begin failures++; $display("FAIL dedup got=%0d/%b exp=1/0100", en_cola, pendientes); end
    ocupado = 1'b0; step();
    checks++; if (destino !== 3'b010) begin failures++; $display("FAIL dedup_issue got=%b exp=010", destino); end
    ocupado = 1'b1; step();
    ocupado = 1'b0; step();
    checks++; if (destino !== 3'b110 || pendientes !== 4'b0000) begin failures++; $display("FAIL dedup_done got=%b/%b exp=110/0000", destino, pendientes); end
    ocupado = 1'b1;
    botones = 4'b0100; step();
    botones = 4'b0000;
    checks++; if (pendientes !== 4'b0100) begin failures++; $display("FAIL repress got=%b exp=0100", pendientes); end
    step();
    checks++; if (en_cola !== 5'd1) begin failures++; $display("FAIL repress_q got=%0d exp=1", en_cola); end
  endtask

  task automatic test_already_there();
    apply_reset();
    piso = 2'b10;
    botones = 4'b0100; step();
    botones = 4'b0000; step(); step();
    checks++; if (destino !== 3'b010) begin failures++; $display("FAIL here_issue got=%b exp=010", destino); end
    step();
    checks++; if (destino !== 3'b110 || pendientes !== 4'b0000) begin failures++; $display("FAIL here_done got=%b/%b exp=110/0000", destino, pendientes); end
  endtask

  task automatic test_full_depth2();
    apply_reset();
    ocupado2 = 1'b1;
    botones2 = 4'b1111; step();
    botones2 = 4'b0000; step(); step(); step();
    checks++; if (en_cola2 !== 5'd2 || llena2 !== 1'b1 || pendientes2 !== 4'b1111) begin failures++; $display("FAIL full got=%0d/%b/%b exp=2/1/1111", en_cola2, llena2, pendientes2); end
    for (int k = 0; k < 4; k++) begin
      ocupado2 = 1'b0; step();
      checks++; if (destino2 !== {1'b0, 2'(k)}) begin failures++; $display("FAIL full_issue%0d got=%b exp=0%b", k, destino2, 2'(k)); end
      ocupado2 = 1'b1; step();
      ocupado2 = 1'b0; step();
      checks++; if (destino2 !== {1'b1, 2'(k)}) begin failures++; $display("FAIL full_done%0d got=%b exp=1%b", k, destino2, 2'(k)); end
    end
    checks++; if (pendientes2 !== 4'b0000 || en_cola2 !== 5'd0 || llena2 !== 1'b0) begin failures++; $display("FAIL full_drain got=%b/%0d/%b exp=0000/0/0", pendientes2, en_cola2, llena2); end
  endtask

  task automatic test_reset_in_flight();
    apply_reset();
    botones = 4'b1111; step();
    botones = 4'b0000; step(); step();
    ocupado = 1'b1; step(); step();
    checks++; if (en_cola !== 5'd3 || destino !== 3'b000) begin failures++; $display("FAIL busy_q got=%0d/%b exp=3/000", en_cola, destino); end
    #2 rst = 1'b1;
    #1;
    checks++; if (destino !== 3'b111 || en_cola !== 5'd0 || pendientes !== 4'b0000 || llena !== 1'b0) begin failures++; $display("FAIL async_rst got=%b/%0d/%b/%b exp=111/0/0000/0", destino, en_cola, pendientes, llena); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_descarte();
    apply_reset();
    piso = 2'b01; puertas = 1'b1; ocupado = 1'b1;
    botones = 4'b0010; step();
    botones = 4'b0000;
`ifdef DESCARTE_PISO_ACTUAL_EN
    checks++; if (pendientes !== 4'b0000) begin failures++; $display("FAIL descarte got=%b exp=0000", pendientes); end
`else
    checks++; if (pendientes !== 4'b0010) begin failures++; $display("FAIL descarte got=%b exp=0010", pendientes); end
`endif
    puertas = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_dedup();
    test_already_there();
    test_full_depth2();
    test_reset_in_flight();
    test_descarte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
